uint64_scan: RTL and testbench



---
 rtl/uint64_scan.sv | 104 ++++++++++
 tb/tb_uint64_scan.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uint64_scan.sv
// uint64_scan: 8x8 key-matrix scanner with frame debounce and valid/ack image handoff
//
// Ports:
//   CLK     in   system clock, rising edge
//   RST     in   asynchronous reset, active-high
//   EN      in   scan enable
//   column  in   [7:0]  asynchronous column return lines, active-high
//   row     out  [7:0]  one-hot row drive
//   data    out  [63:0] debounced image, row r column c at bit 8r+c
//   valid   out  new image available
//   ack     in   consumer acknowledge pulse
//   overrun out  sticky "image replaced before ack" flag (only with UINT64_SCAN_OVR_EN)
//
// Optional feature macro: UINT64_SCAN_OVR_EN
module uint64_scan #(
   parameter int SETTLE   = 3,
   parameter int DEBOUNCE = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        EN,
   input  logic [7:0]  column,
   output logic [7:0]  row,
   output logic [63:0] data,
   output logic        valid,
`ifdef UINT64_SCAN_OVR_EN
   output logic        overrun,
`endif
   input  logic        ack
);
   localparam int CW = $clog2(SETTLE + 1);
   localparam int SW = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] ST = CW'(SETTLE);
   localparam logic [SW-1:0] DB = SW'(DEBOUNCE);

   logic [7:0]    col_m_q, col_s_q;
   logic [7:0]    row_q, row_d;
   logic [2:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0]   scr_q, scr_d;
   logic [63:0]   prev_q, prev_d;
   logic [SW-1:0] stab_q, stab_d, stab_n;
   logic [63:0]   data_q, data_d;
   logic          valid_q, valid_d;
   logic          samp, fend, upd;

   // row_q == 0 marks the first enabled cycle: the row is raised before the
   // settle count starts so every row, including row 0, gets SETTLE+1 cycles
   always_comb begin
      samp = EN && row_q != 8'h00 && cnt_q == ST;
      fend = samp && idx_q == 3'd7;
      scr_d = scr_q;
      if (samp) scr_d[{idx_q, 3'b000} +: 8] = col_s_q;
      stab_n = (scr_d == prev_q) ? ((stab_q == DB) ? DB : stab_q + 1'b1) : SW'(1);
      upd = fend && stab_n >= DB && scr_d != data_q;
      prev_d = fend ? scr_d : prev_q;
      data_d = upd ? scr_d : data_q;
      valid_d = upd || (valid_q && !ack);
      idx_d = !EN ? 3'd0 : samp ? idx_q + 3'd1 : idx_q;
      cnt_d = (!EN || samp || row_q == 8'h00) ? '0 : cnt_q + 1'b1;
      stab_d = !EN ? '0 : fend ? stab_n : stab_q;
      row_d = EN ? 8'h01 << idx_d : 8'h00;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         col_m_q <= '0;
         col_s_q <= '0;
         row_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         scr_q   <= '0;
         prev_q  <= '0;
         stab_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         col_m_q <= column;
         col_s_q <= col_m_q;
         row_q   <= row_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         scr_q   <= scr_d;
         prev_q  <= prev_d;
         stab_q  <= stab_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

`ifdef UINT64_SCAN_OVR_EN
   logic ovr_q, ovr_d;
   assign ovr_d = ack ? 1'b0 : (upd && valid_q) ? 1'b1 : ovr_q;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) ovr_q <= 1'b0;
      else ovr_q <= ovr_d;
   end
   assign overrun = ovr_q;
`endif

   assign row   = row_q;
   assign data  = data_q;
   assign valid = valid_q;
endmodule

// File: tb/tb_uint64_scan.sv
// tb_uint64_scan: frame-level model check of uint64_scan driving a simulated key matrix
module tb_uint64_scan;
   localparam int S = 3;
   localparam int D = 2;
   localparam int FRAME = 8 * (S + 1);
   localparam logic [63:0] K1 = 64'h0000_0000_0020_0000;
   localparam logic [63:0] G  = 64'h0100_0000_0000_0000;
   localparam logic [63:0] K2 = 64'h0100_0000_0020_0000;
   localparam logic [63:0] K3 = 64'h0100_0000_0020_0001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        ack = 1'b0;
   logic [63:0] keys = K1;
   logic [7:0]  column;
   logic [7:0]  row_w;
   logic [63:0] data_w;
   logic        valid_w;
`ifdef UINT64_SCAN_OVR_EN
   logic        ovr_w;
`endif

   int checks = 0;
   int errors = 0;

   uint64_scan #(.SETTLE(S), .DEBOUNCE(D)) dut (
      .CLK(clk),
      .RST(rst),
      .EN(en),
      .column(column),
      .row(row_w),
      .data(data_w),
      .valid(valid_w),
`ifdef UINT64_SCAN_OVR_EN
      .overrun(ovr_w),
`endif
      .ack(ack)
   );

   always #5 clk = ~clk;

   always_comb begin
      column = 8'h00;
      for (int r = 0; r < 8; r++) if (row_w[r]) column = column | keys[8*r +: 8];
   end

   // frame-level model: a scan position counter plus the debounce/handshake rules
   bit          m_on = 1'b0;
   int          m_t = 0;
   int          m_stab = 0;
   int          frames = 0;
   logic [63:0] m_prev = '0;
   logic [63:0] m_data = '0;
   bit          m_valid = 1'b0;
   bit          m_ovr = 1'b0;
   bit          m_upd;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_on = 1'b0; m_t = 0; m_stab = 0; m_prev = '0;
         m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
      end else begin
         m_upd = 1'b0;
         if (!en) begin
            m_on = 1'b0; m_t = 0; m_stab = 0;
         end else if (!m_on) begin
            m_on = 1'b1; m_t = 0;
         end else if (m_t == FRAME - 1) begin
            m_t = 0;
            frames++;
            m_stab = (keys == m_prev) ? ((m_stab < D) ? m_stab + 1 : D) : 1;
            m_prev = keys;
            m_upd = (m_stab >= D) && (keys != m_data);
         end else m_t++;
         if (ack) m_ovr = 1'b0;
         else if (m_upd && m_valid) m_ovr = 1'b1;
         m_valid = m_upd ? 1'b1 : ack ? 1'b0 : m_valid;
         if (m_upd) m_data = keys;
      end
   end

   function automatic logic [7:0] exp_row();
      logic [7:0] one = 8'h01;
      return m_on ? one << (m_t / (S + 1)) : 8'h00;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("row", {56'd0, row_w}, {56'd0, exp_row()});
         chk("data", data_w, m_data);
         chk("valid", {63'd0, valid_w}, {63'd0, m_valid});
`ifdef UINT64_SCAN_OVR_EN
         chk("overrun", {63'd0, ovr_w}, {63'd0, m_ovr});
`endif
      end
   end

   task automatic wait_frames(input int n);
      int f0 = frames;
      int c = 0;
      while (frames < f0 + n && c < FRAME * n + 80) begin
         @(negedge clk);
         c++;
      end
      chk("wait_frames", 64'(frames >= f0 + n), 64'd1);
   endtask

   task automatic wait_row(input logic [7:0] r);
      int c = 0;
      while (!(exp_row() == r && m_t % (S + 1) == 1) && c < 2 * FRAME) begin
         @(negedge clk);
         c++;
      end
      chk("wait_row", {56'd0, exp_row()}, {56'd0, r});
   endtask

   task automatic wait_last();
      int c = 0;
      while (m_t != FRAME - 1 && c < 2 * FRAME) begin
         @(negedge clk);
         c++;
      end
      chk("wait_last", 64'(m_t), 64'(FRAME - 1));
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   initial begin
      int cyc;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      while (!valid_w && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1)  chk("row_c1", {56'd0, row_w}, 64'h01);
         if (cyc == 5)  chk("row_c5", {56'd0, row_w}, 64'h02);
         if (cyc == 29) chk("row_c29", {56'd0, row_w}, 64'h80);
         if (cyc == 33) chk("row_c33", {56'd0, row_w}, 64'h01);
      end
      chk("valid_latency_ok", 64'(cyc >= 1 && cyc <= 68), 64'd1);
      chk("data_first", data_w, 64'h0000_0000_0020_0000);
      pulse_ack();
      chk("valid_after_ack", {63'd0, valid_w}, 64'd0);
      wait_frames(2);
      chk("no_revalid", {63'd0, valid_w}, 64'd0);

      wait_frames(1);
      keys = K1 | G;
      wait_frames(1);
      keys = K1;
      wait_frames(2);
      chk("glitch_data", data_w, K1);
      chk("glitch_valid", {63'd0, valid_w}, 64'd0);
      keys = K2;
      wait_frames(2);
      chk("held_bit56", {63'd0, data_w[56]}, 64'd1);
      chk("held_valid", {63'd0, valid_w}, 64'd1);
      pulse_ack();

      wait_frames(1);
      keys = K1;
      wait_frames(1);
      wait_last();
      pulse_ack();
      chk("ack_upd_valid", {63'd0, valid_w}, 64'd1);
      chk("ack_upd_data", data_w, K1);
      pulse_ack();

      wait_row(8'h10);
      #2 rst = 1'b1;
      #1;
      chk("rst_row", {56'd0, row_w}, 64'd0);
      chk("rst_data", data_w, 64'd0);
      chk("rst_valid", {63'd0, valid_w}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("row_after_rst", {56'd0, row_w}, 64'h01);
      wait_frames(2);
      chk("rst_reacquire", data_w, K1);

      keys = K2;
      wait_frames(1);
      wait_row(8'h20);
      en = 1'b0;
      @(negedge clk);
      chk("row_en0", {56'd0, row_w}, 64'd0);
      chk("data_en0", data_w, K1);
      chk("valid_en0", {63'd0, valid_w}, 64'd1);
      pulse_ack();
      chk("ack_en0", {63'd0, valid_w}, 64'd0);
      repeat (8) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      chk("row_reen", {56'd0, row_w}, 64'h01);
      wait_frames(1);
      chk("reen_no_update", data_w, K1);
      wait_frames(1);
      chk("reen_update", data_w, K2);
      chk("reen_valid", {63'd0, valid_w}, 64'd1);

      keys = K3;
      wait_frames(2);
      chk("overwrite_data", data_w, K3);
      chk("overwrite_valid", {63'd0, valid_w}, 64'd1);
`ifdef UINT64_SCAN_OVR_EN
      chk("overrun_set", {63'd0, ovr_w}, 64'd1);
      pulse_ack();
      chk("overrun_clr", {63'd0, ovr_w}, 64'd0);
      chk("overrun_valid_clr", {63'd0, valid_w}, 64'd0);
`endif
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
